// File: rtl/ifetch_mem_bridge_if.sv
// Fetch request/response interfaces between the core front end and the
// instruction-side bridge.

interface data_req_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic            rd;
  logic            wr;
  logic [XLEN-1:0] addr;
  logic [63:0]     data;

  modport in  (input  valid, rd, wr, addr, data);
  modport out (output valid, rd, wr, addr, data);
endinterface

interface data_res_if;
  logic        valid;
  logic [63:0] data;

  modport in  (input  valid, data);
  modport out (output valid, data);
endinterface

// File: rtl/ifetch_mem_bridge.sv
// Instruction-pair fetch bridge: queues 64-bit fetch requests and serves each
// one as two in-order 32-bit reads from a variable-latency memory port.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a queued fetch; pops the FIFO head
// S_REQ_LO  | presenting the low-word read, waiting for mem_req_ready_i
// S_WAIT_LO | low-word read accepted, waiting for its data
// S_REQ_HI  | presenting the high-word read, waiting for mem_req_ready_i
// S_WAIT_HI | high-word read accepted, waiting for its data
// S_RESP    | response valid pulse; data register loads on exit
// S_DRAIN   | flushed fetch: swallow the one outstanding read response

module ifetch_mem_bridge #(
  parameter int XLEN      = 32,
  parameter int REQ_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  data_req_if.in          cpu_req_i,
  data_res_if.out         cpu_res_o,
  input  logic            flush_i,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_rsp_valid_i,
  input  logic [31:0]     mem_rsp_data_i,
  output logic            overflow_o
);

  localparam int AW = $clog2(REQ_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = XLEN - 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_LO,
    S_WAIT_LO,
    S_REQ_HI,
    S_WAIT_HI,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t          state_q;
  logic [BW-1:0]   fifo_q [REQ_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic            overflow_q;
  logic [BW-1:0]   base_q;
  logic [31:0]     lo_q;
  logic [31:0]     hi_q;
  logic            kill_q;
  logic            mem_req_valid_q;
  logic [XLEN-1:0] mem_addr_q;
  logic            res_valid_q;
  logic [63:0]     res_data_q;

  logic            fifo_empty;
  logic            fifo_full;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            drop;
  logic [BW-1:0]   head;

  // Only the 8-byte-aligned part of the address matters; the write data
  // field of the request is never used by a read-only fetch port.
  logic unused_bits;
  assign unused_bits = ^{cpu_req_i.data, cpu_req_i.addr[2:0]};

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push_req = cpu_req_i.valid & cpu_req_i.rd & ~cpu_req_i.wr & ~flush_i;
  assign pop      = (state_q == S_IDLE) & ~fifo_empty & ~flush_i;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push     = push_req & (~fifo_full | pop);
  assign drop     = push_req & fifo_full & ~pop;
  assign head     = fifo_q[rd_ptr_q[AW-1:0]];

  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_addr_o      = mem_addr_q;
  assign overflow_o      = overflow_q;
  assign cpu_res_o.valid = res_valid_q;
  assign cpu_res_o.data  = res_data_q;

  // FIFO storage; contents need no reset because the pointers guard them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q[AW-1:0]] <= cpu_req_i.addr[XLEN-1:3];
    end
  end

  // FIFO pointers, flush clear and sticky overflow flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      rd_ptr_q <= wr_ptr_q;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Fetch sequencer with registered memory-port and response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      base_q          <= '0;
      lo_q            <= '0;
      hi_q            <= '0;
      kill_q          <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      res_valid_q     <= 1'b0;
      res_data_q      <= '0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            base_q          <= head;
            mem_req_valid_q <= 1'b1;
            mem_addr_q      <= {head, 3'b000};
            state_q         <= S_REQ_LO;
          end
        end
        S_REQ_LO: begin
          // A flush cannot withdraw a presented request; remember it instead.
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            kill_q          <= 1'b0;
            state_q         <= (kill_q | flush_i) ? S_DRAIN : S_WAIT_LO;
          end else if (flush_i) begin
            kill_q <= 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (mem_rsp_valid_i) begin
            lo_q <= mem_rsp_data_i;
            if (flush_i) begin
              state_q <= S_IDLE;
            end else begin
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= {base_q, 3'b100};
              state_q         <= S_REQ_HI;
            end
          end else if (flush_i) begin
            state_q <= S_DRAIN;
          end
        end
        S_REQ_HI: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            kill_q          <= 1'b0;
            state_q         <= (kill_q | flush_i) ? S_DRAIN : S_WAIT_HI;
          end else if (flush_i) begin
            kill_q <= 1'b1;
          end
        end
        S_WAIT_HI: begin
          if (mem_rsp_valid_i) begin
            if (flush_i) begin
              state_q <= S_IDLE;
            end else begin
              hi_q        <= mem_rsp_data_i;
              res_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end
          end else if (flush_i) begin
            state_q <= S_DRAIN;
          end
        end
        S_RESP: begin
          // Data lands one cycle after the valid pulse.
          res_data_q <= {hi_q, lo_q};
          state_q    <= S_IDLE;
        end
        S_DRAIN: begin
          if (mem_rsp_valid_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
